// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO family.
// Depth, level width and read-mode selectors live here so every file agrees on them.
package fifo_pkg;

   localparam int FIFO_MODE_STD  = 0;
   localparam int FIFO_MODE_FWFT = 1;

   function automatic int depth(input int aw);
      return 1 << aw;
   endfunction

   // One extra bit so a full FIFO (2^AW words) is representable.
   function automatic int level_w(input int aw);
      return aw + 1;
   endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// FIFO storage: 2^AW x DW register array, synchronous write, asynchronous read.
// Contents are deliberately left unreset.
import fifo_pkg::*;

module fifo_sync_ram #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [depth(AW)];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with level counter, almost-full/empty thresholds, sticky
// overflow/underflow flags and selectable standard or first-word-fall-through read.
import fifo_pkg::*;

module fifo_sync #(
   parameter int DW     = 8,
   parameter int AW     = 4,
   parameter int AF_LVL = (1 << AW) - 2,
   parameter int AE_LVL = 2,
   parameter int FWFT   = FIFO_MODE_STD
) (
   input  logic          I_CLK,
   input  logic          I_RST,
   input  logic          I_WR_EN,
   input  logic [DW-1:0] I_WR_DATA,
   input  logic          I_RD_EN,
   input  logic          I_CLR_ERR,
   output logic [DW-1:0] O_RD_DATA,
   output logic          O_RD_VALID,
   output logic          O_FULL,
   output logic          O_ALMOST_FULL,
   output logic          O_EMPTY,
   output logic          O_ALMOST_EMPTY,
   output logic [AW:0]   O_LEVEL,
   output logic          O_OVERFLOW,
   output logic          O_UNDERFLOW
);

   localparam int          LW       = level_w(AW);
   localparam logic [AW:0] FULL_LVL = LW'(depth(AW));
   localparam logic [AW:0] AF_V     = LW'(AF_LVL);
   localparam logic [AW:0] AE_V     = LW'(AE_LVL);

   logic [AW:0]   wr_ptr, rd_ptr, level, next_level;
   logic          wr_acc, rd_acc;
   logic [DW-1:0] head;

   // Acceptance uses the registered flags only, so a same-cycle pop never
   // frees a slot for a push when full (and vice versa when empty).
   assign wr_acc  = I_WR_EN & ~O_FULL;
   assign rd_acc  = I_RD_EN & ~O_EMPTY;
   assign O_LEVEL = level;

   always_comb begin
      next_level = level;
      unique case ({wr_acc, rd_acc})
         2'b10:   next_level = level + 1'b1;
         2'b01:   next_level = level - 1'b1;
         default: next_level = level;
      endcase
   end

   always_ff @(posedge I_CLK) begin
      if (I_RST) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         level          <= '0;
         O_FULL         <= 1'b0;
         O_ALMOST_FULL  <= 1'b0;
         O_EMPTY        <= 1'b1;
         O_ALMOST_EMPTY <= 1'b1;
         O_OVERFLOW     <= 1'b0;
         O_UNDERFLOW    <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
         level          <= next_level;
         O_FULL         <= (next_level == FULL_LVL);
         O_EMPTY        <= (next_level == '0);
         O_ALMOST_FULL  <= (next_level >= AF_V);
         O_ALMOST_EMPTY <= (next_level <= AE_V);
         // A new error wins over a same-cycle clear.
         O_OVERFLOW     <= (I_WR_EN & O_FULL)  | (O_OVERFLOW  & ~I_CLR_ERR);
         O_UNDERFLOW    <= (I_RD_EN & O_EMPTY) | (O_UNDERFLOW & ~I_CLR_ERR);
      end
   end

   fifo_sync_ram #(.DW(DW), .AW(AW)) u_ram (
      .clk   (I_CLK),
      .we    (wr_acc),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (I_WR_DATA),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (head)
   );

   generate
      if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
         assign O_RD_DATA  = head;
         assign O_RD_VALID = ~O_EMPTY;
      end else begin : g_std
         always_ff @(posedge I_CLK) begin
            if (I_RST) begin
               O_RD_DATA  <= '0;
               O_RD_VALID <= 1'b0;
            end else begin
               O_RD_VALID <= rd_acc;
               if (rd_acc) O_RD_DATA <= head;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_fifo_sync.sv
// Drives a standard-mode and an FWFT-mode fifo_sync with identical stimulus and
// compares both against a queue-based reference after every clock.
module tb_fifo_sync;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int DEPTH = 16;
   localparam int AF = 14;
   localparam int AE = 2;

   logic          clk = 1'b0;
   logic          rst, wr_en, rd_en, clr_err;
   logic [DW-1:0] wr_data;

   logic [DW-1:0] s_data, f_data;
   logic          s_valid, s_full, s_af, s_empty, s_ae, s_ovf, s_udf;
   logic          f_valid, f_full, f_af, f_empty, f_ae, f_ovf, f_udf;
   logic [AW:0]   s_level, f_level;

   int checks = 0;
   int failures = 0;

   bit [7:0] q[$];
   bit       m_ovf, m_udf, m_valid;
   bit [7:0] m_data;

   always #5 clk = ~clk;

   fifo_sync #(.DW(DW), .AW(AW), .AF_LVL(AF), .AE_LVL(AE), .FWFT(0)) u_std (
      .I_CLK(clk), .I_RST(rst), .I_WR_EN(wr_en), .I_WR_DATA(wr_data),
      .I_RD_EN(rd_en), .I_CLR_ERR(clr_err),
      .O_RD_DATA(s_data), .O_RD_VALID(s_valid), .O_FULL(s_full),
      .O_ALMOST_FULL(s_af), .O_EMPTY(s_empty), .O_ALMOST_EMPTY(s_ae),
      .O_LEVEL(s_level), .O_OVERFLOW(s_ovf), .O_UNDERFLOW(s_udf));

   fifo_sync #(.DW(DW), .AW(AW), .AF_LVL(AF), .AE_LVL(AE), .FWFT(1)) u_fwft (
      .I_CLK(clk), .I_RST(rst), .I_WR_EN(wr_en), .I_WR_DATA(wr_data),
      .I_RD_EN(rd_en), .I_CLR_ERR(clr_err),
      .O_RD_DATA(f_data), .O_RD_VALID(f_valid), .O_FULL(f_full),
      .O_ALMOST_FULL(f_af), .O_EMPTY(f_empty), .O_ALMOST_EMPTY(f_ae),
      .O_LEVEL(f_level), .O_OVERFLOW(f_ovf), .O_UNDERFLOW(f_udf));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference behaviour at one clock edge, from the FIFO rules directly.
   task automatic model_edge(input bit r, input bit w, input bit [7:0] d, input bit rd, input bit c);
      bit full, empty, wacc, racc;
      if (r) begin
         q.delete();
         m_ovf = 0; m_udf = 0; m_valid = 0; m_data = 8'h00;
      end else begin
         full  = (q.size() == DEPTH);
         empty = (q.size() == 0);
         wacc  = w && !full;
         racc  = rd && !empty;
         m_ovf = (w && full)   ? 1'b1 : (c ? 1'b0 : m_ovf);
         m_udf = (rd && empty) ? 1'b1 : (c ? 1'b0 : m_udf);
         m_valid = racc;
         if (racc) m_data = q.pop_front();
         if (wacc) q.push_back(d);
      end
   endtask

   task automatic check_all();
      int n;
      n = q.size();
      chk("std_level", 32'(s_level), 32'(n));
      chk("std_full",  32'(s_full),  32'(n == DEPTH));
      chk("std_empty", 32'(s_empty), 32'(n == 0));
      chk("std_afull", 32'(s_af),    32'(n >= AF));
      chk("std_aempty",32'(s_ae),    32'(n <= AE));
      chk("std_ovf",   32'(s_ovf),   32'(m_ovf));
      chk("std_udf",   32'(s_udf),   32'(m_udf));
      chk("std_valid", 32'(s_valid), 32'(m_valid));
      chk("std_data",  32'(s_data),  32'(m_data));
      chk("fwft_level",32'(f_level), 32'(n));
      chk("fwft_full", 32'(f_full),  32'(n == DEPTH));
      chk("fwft_ovf",  32'(f_ovf),   32'(m_ovf));
      chk("fwft_udf",  32'(f_udf),   32'(m_udf));
      chk("fwft_valid",32'(f_valid), 32'(n != 0));
      if (n != 0) chk("fwft_head", 32'(f_data), 32'(q[0]));
   endtask

   task automatic step(input bit r, input bit w, input bit [7:0] d, input bit rd, input bit c);
      rst = r; wr_en = w; wr_data = d; rd_en = rd; clr_err = c;
      @(posedge clk);
      model_edge(r, w, d, rd, c);
      #1;
      check_all();
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = '0;
      @(negedge clk);

      // Reset state
      step(1, 0, 8'h00, 0, 0);
      step(1, 0, 8'h00, 0, 0);

      // Fill 0x00..0x0F, then overflow attempt
      for (int i = 0; i < DEPTH; i++) step(0, 1, 8'(i), 0, 0);
      chk("full_after_16", 32'(s_full), 32'd1);
      step(0, 1, 8'hEE, 0, 0);
      chk("ovf_17th", 32'(s_ovf), 32'd1);
      step(0, 0, 8'h00, 0, 1);

      // Drain in order, then underflow attempt
      for (int i = 0; i < DEPTH; i++) begin
         step(0, 0, 8'h00, 1, 0);
         chk("drain_data", 32'(s_data), 32'(i));
      end
      step(0, 0, 8'h00, 1, 0);
      chk("udf_extra", 32'(s_udf), 32'd1);
      step(0, 0, 8'h00, 0, 1);

      // FWFT single word presented with no read, then popped
      step(1, 0, 8'h00, 0, 0);
      step(0, 1, 8'hA5, 0, 0);
      chk("fwft_a5_valid", 32'(f_valid), 32'd1);
      chk("fwft_a5_data",  32'(f_data),  32'hA5);
      step(0, 0, 8'h00, 1, 0);
      chk("fwft_a5_empty", 32'(f_empty), 32'd1);

      // Level 8 with 40 cycles of simultaneous read/write
      for (int i = 0; i < 8; i++) step(0, 1, 8'($urandom), 0, 0);
      for (int i = 0; i < 40; i++) step(0, 1, 8'($urandom), 1, 0);
      chk("steady_level", 32'(s_level), 32'd8);

      // Full plus simultaneous read and write: read wins, write rejected
      for (int i = 0; i < 8; i++) step(0, 1, 8'($urandom), 0, 0);
      step(0, 1, 8'h5A, 1, 0);
      chk("full_rw_level", 32'(s_level), 32'd15);
      chk("full_rw_ovf",   32'(s_ovf),   32'd1);

      // Clear coinciding with a fresh overflow keeps the flag set
      step(0, 1, 8'h3C, 0, 1);
      step(0, 1, 8'h3D, 0, 1);
      chk("clr_vs_set", 32'(s_ovf), 32'd1);
      step(0, 0, 8'h00, 0, 1);

      // Randomised traffic
      for (int i = 0; i < 400; i++)
         step(0, ($urandom_range(0, 99) < 55), 8'($urandom),
              ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 5));

      // Reset at level 9 mid-burst, then fresh data
      step(1, 0, 8'h00, 0, 0);
      for (int i = 0; i < 9; i++) step(0, 1, 8'($urandom), 0, 0);
      step(1, 1, 8'hFF, 1, 0);
      chk("rst_mid_level", 32'(s_level), 32'd0);
      chk("rst_mid_empty", 32'(s_empty), 32'd1);
      step(0, 1, 8'hC3, 0, 0);
      step(0, 0, 8'h00, 1, 0);
      chk("post_rst_data", 32'(s_data), 32'hC3);
      step(0, 0, 8'h00, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
